// File: rtl/pul_profile_pkg.sv
// Shared encodings and widths for the pulse-period profile generator.
// State codes double as the externally visible phase field.
package pul_profile_pkg;

  localparam int RAW_W        = 49;
  localparam int PERIOD_W_DEF = 32;
  localparam int STEP_W_DEF   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCEL = 2'b01,
    ST_DECEL = 2'b10,
    ST_CONST = 2'b11
  } state_t;

endpackage

// File: rtl/pul_wr_pacer.sv
// FIFO write pacer: grants a write only when the FIFO is not full and no write
// was issued in the previous cycle, leaving the full flag a cycle to settle.
module pul_wr_pacer #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_req,
  input  logic         i_abort,
  input  logic [W-1:0] i_data,
  input  logic         i_fifo_full,
  output logic         o_grant,
  output logic         o_fifo_wr,
  output logic [W-1:0] o_fifo_wdata
);

  logic         r_wr;
  logic [W-1:0] r_wdata;
  logic         w_grant;

  assign w_grant      = i_req & ~i_abort & ~i_fifo_full & ~r_wr;
  assign o_grant      = w_grant;
  assign o_fifo_wr    = r_wr;
  assign o_fifo_wdata = r_wdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_wr <= w_grant;
      if (w_grant) r_wdata <= i_data;
    end
  end

endmodule

// File: rtl/pul_profile_gen.sv
// Trapezoidal pulse-period profile writer: accel table, optional constant
// segment (PUL_PROFILE_CONST_EN), then the mirrored decel table.
module pul_profile_gen
  import pul_profile_pkg::*;
#(
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int STEP_W   = STEP_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [PERIOD_W-1:0] period_start,
  input  logic [PERIOD_W-1:0] period_min,
  input  logic [PERIOD_W-1:0] period_delta,
  input  logic [STEP_W-1:0]   accel_steps,
`ifdef PUL_PROFILE_CONST_EN
  input  logic [31:0]         const_steps,
`endif
  input  logic                fifo_full,
  output logic                fifo_wr,
  output logic [PERIOD_W-1:0] fifo_wdata,
  output logic                busy,
  output logic                done,
  output logic [1:0]          phase,
  output logic [31:0]         wr_count
);

  state_t                    r_state, w_state_nxt;
  logic signed [RAW_W-1:0]   r_raw, w_raw_nxt;
  logic [STEP_W-1:0]         r_idx, w_idx_nxt, r_n, w_n_nxt;
  logic [PERIOD_W-1:0]       r_min, w_min_nxt, r_delta, w_delta_nxt;
  logic [31:0]               r_wr_count, w_wr_count_nxt;
  logic                      r_done, w_done_nxt;
  logic                      r_fin, w_fin_nxt;
  logic [31:0]               r_cnt, w_cnt_nxt, r_const, w_const_nxt;
  logic signed [RAW_W-1:0]   w_min_ext, w_delta_ext;
  logic [PERIOD_W-1:0]       w_entry;
  logic                      w_req, w_grant, w_last;

  assign w_min_ext   = {{(RAW_W-PERIOD_W){1'b0}}, r_min};
  assign w_delta_ext = {{(RAW_W-PERIOD_W){1'b0}}, r_delta};
  assign w_entry     = (r_raw < w_min_ext) ? r_min : r_raw[PERIOD_W-1:0];
  assign w_req       = (r_state != ST_IDLE) && !r_fin;
  assign w_last      = (r_idx == r_n - STEP_W'(1));

  pul_wr_pacer #(.W(PERIOD_W)) u_pacer (
    .clk          (clk),
    .rst          (rst),
    .i_req        (w_req),
    .i_abort      (abort),
    .i_data       (w_entry),
    .i_fifo_full  (fifo_full),
    .o_grant      (w_grant),
    .o_fifo_wr    (fifo_wr),
    .o_fifo_wdata (fifo_wdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_raw      <= '0;
      r_idx      <= '0;
      r_n        <= '0;
      r_min      <= '0;
      r_delta    <= '0;
      r_wr_count <= '0;
      r_done     <= 1'b0;
      r_fin      <= 1'b0;
      r_cnt      <= '0;
      r_const    <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_raw      <= w_raw_nxt;
      r_idx      <= w_idx_nxt;
      r_n        <= w_n_nxt;
      r_min      <= w_min_nxt;
      r_delta    <= w_delta_nxt;
      r_wr_count <= w_wr_count_nxt;
      r_done     <= w_done_nxt;
      r_fin      <= w_fin_nxt;
      r_cnt      <= w_cnt_nxt;
      r_const    <= w_const_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_raw_nxt      = r_raw;
    w_idx_nxt      = r_idx;
    w_n_nxt        = r_n;
    w_min_nxt      = r_min;
    w_delta_nxt    = r_delta;
    w_wr_count_nxt = w_grant ? r_wr_count + 32'd1 : r_wr_count;
    w_done_nxt     = 1'b0;
    w_fin_nxt      = r_fin;
    w_cnt_nxt      = r_cnt;
    w_const_nxt    = r_const;
    case (r_state)
      ST_IDLE: begin
        if (start && !abort) begin
          w_n_nxt        = accel_steps;
          w_min_nxt      = period_min;
          w_delta_nxt    = period_delta;
          w_raw_nxt      = {{(RAW_W-PERIOD_W){1'b0}}, period_start};
          w_idx_nxt      = '0;
          w_wr_count_nxt = '0;
          w_cnt_nxt      = '0;
          w_fin_nxt      = 1'b0;
`ifdef PUL_PROFILE_CONST_EN
          w_const_nxt    = const_steps;
`else
          w_const_nxt    = '0;
`endif
          if (accel_steps == '0) w_done_nxt  = 1'b1;
          else                   w_state_nxt = ST_ACCEL;
        end
      end
      ST_ACCEL: begin
        if (w_grant) begin
          if (w_last) begin
`ifdef PUL_PROFILE_CONST_EN
            w_state_nxt = (r_const != '0) ? ST_CONST : ST_DECEL;
`else
            w_state_nxt = ST_DECEL;
`endif
          end else begin
            w_raw_nxt = r_raw - w_delta_ext;
            w_idx_nxt = r_idx + STEP_W'(1);
          end
        end
      end
`ifdef PUL_PROFILE_CONST_EN
      ST_CONST: begin
        if (w_grant) begin
          if (r_cnt == r_const - 32'd1) w_state_nxt = ST_DECEL;
          else                          w_cnt_nxt   = r_cnt + 32'd1;
        end
      end
`endif
      ST_DECEL: begin
        // r_fin holds the state one cycle so done lands after the final write
        if (r_fin) begin
          w_state_nxt = ST_IDLE;
          w_done_nxt  = 1'b1;
          w_fin_nxt   = 1'b0;
        end else if (w_grant) begin
          w_raw_nxt = r_raw + w_delta_ext;
          if (r_idx == '0) w_fin_nxt = 1'b1;
          else             w_idx_nxt = r_idx - STEP_W'(1);
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (abort && r_state != ST_IDLE) begin
      w_state_nxt = ST_IDLE;
      w_done_nxt  = 1'b0;
      w_fin_nxt   = 1'b0;
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign done     = r_done;
  assign phase    = r_state;
  assign wr_count = r_wr_count;

endmodule

// File: tb/tb_pul_profile_gen.sv
// Scoreboard bench for pul_profile_gen; the const segment test runs only
// when PUL_PROFILE_CONST_EN is defined.
module tb_pul_profile_gen;

  logic        clk = 1'b0;
  logic        rst, start, abort, fifo_full;
  logic [31:0] period_start, period_min, period_delta;
  logic [15:0] accel_steps;
  logic [31:0] const_steps;
  logic        fifo_wr, busy, done;
  logic [31:0] fifo_wdata, wr_count;
  logic [1:0]  phase;

  int n_chk = 0, n_pass = 0;
  int done_cnt = 0, wr_total = 0;
  logic prev_wr = 1'b0, saw_const = 1'b0;
  int sb[$];

  always #5 clk = ~clk;

  pul_profile_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .period_start (period_start),
    .period_min   (period_min),
    .period_delta (period_delta),
    .accel_steps  (accel_steps),
`ifdef PUL_PROFILE_CONST_EN
    .const_steps  (const_steps),
`endif
    .fifo_full    (fifo_full),
    .fifo_wr      (fifo_wr),
    .fifo_wdata   (fifo_wdata),
    .busy         (busy),
    .done         (done),
    .phase        (phase),
    .wr_count     (wr_count)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    else n_pass++;
  endtask

  always @(posedge clk) begin
    logic full_s;
    int   e;
    full_s = fifo_full;
    #1;
    if (phase == 2'b11) saw_const = 1'b1;
    if (done) done_cnt++;
    if (fifo_wr) begin
      wr_total++;
      chk("spacing", prev_wr, 0);
      chk("full_gate", full_s, 0);
      if (sb.size() == 0) chk("unexpected_wr", 1, 0);
      else begin
        e = sb.pop_front();
        chk("entry", fifo_wdata, e);
      end
    end
    prev_wr = fifo_wr;
  end

  task automatic set_params(input int ps, input int d, input int mn, input int n, input int cs);
    period_start = ps; period_delta = d; period_min = mn;
    accel_steps = 16'(n); const_steps = cs;
  endtask

  task automatic push_profile(input int ps, input int d, input int mn, input int n, input int cs);
    int v[$];
    for (int i = 0; i < n; i++) begin
      int e;
      e = ps - i * d;
      if (e < mn) e = mn;
      v.push_back(e);
      sb.push_back(e);
    end
    for (int i = 0; i < cs; i++) sb.push_back(v[n-1]);
    for (int i = n - 1; i >= 0; i--) sb.push_back(v[i]);
  endtask

  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int d0, input int budget);
    int k = 0;
    while (done_cnt == d0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, done_cnt - d0, 1);
  endtask

  task automatic wait_writes(input string tag, input int target, input int budget);
    int k = 0;
    while (wr_total < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(tag, wr_total, target);
  endtask

  initial begin
    int d0, base;
    rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_full = 1'b0;
    set_params(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_wr", fifo_wr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_phase", phase, 0);
    chk("rst_count", wr_count, 0);

    // nominal, with start and parameter changes while busy
    set_params(1000, 100, 200, 5, 0);
    push_profile(1000, 100, 200, 5, 0);
    d0 = done_cnt;
    pulse_start();
    chk("nom_phase", phase, 1);
    chk("nom_busy", busy, 1);
    set_params(7, 3, 1, 2, 0);
    pulse_start();
    wait_done("nom_done", d0, 200);
    chk("nom_count", wr_count, 10);
    chk("nom_sb_empty", sb.size(), 0);
    chk("nom_idle", busy, 0);

    // clamping
    set_params(500, 200, 250, 4, 0);
    push_profile(500, 200, 250, 4, 0);
    d0 = done_cnt;
    pulse_start();
    wait_done("clamp_done", d0, 200);
    chk("clamp_count", wr_count, 8);
    chk("clamp_sb_empty", sb.size(), 0);

    // zero steps
    set_params(1000, 100, 200, 0, 0);
    d0 = done_cnt;
    base = wr_total;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    repeat (5) @(negedge clk);
    chk("zero_done_cnt", done_cnt - d0, 1);
    chk("zero_writes", wr_total - base, 0);
    chk("zero_count", wr_count, 0);

    // backpressure from write 3 for 20 cycles
    set_params(1000, 100, 200, 5, 0);
    push_profile(1000, 100, 200, 5, 0);
    d0 = done_cnt;
    base = wr_total;
    pulse_start();
    wait_writes("bp_reach3", base + 3, 100);
    fifo_full = 1'b1;
    repeat (20) @(negedge clk);
    chk("bp_stall_writes", wr_total - base, 3);
    chk("bp_stall_count", wr_count, 3);
    chk("bp_busy", busy, 1);
    fifo_full = 1'b0;
    wait_done("bp_done", d0, 200);
    chk("bp_count", wr_count, 10);
    chk("bp_sb_empty", sb.size(), 0);

    // abort after write 4, then restart
    push_profile(1000, 100, 200, 5, 0);
    d0 = done_cnt;
    base = wr_total;
    pulse_start();
    wait_writes("ab_reach4", base + 4, 100);
    abort = 1'b1;
    @(negedge clk) abort = 1'b0;
    chk("ab_busy", busy, 0);
    chk("ab_phase", phase, 0);
    chk("ab_count", wr_count, 4);
    repeat (6) @(negedge clk);
    chk("ab_no_done", done_cnt - d0, 0);
    chk("ab_no_more_wr", wr_total - base, 4);
    sb.delete();
    push_profile(1000, 100, 200, 5, 0);
    d0 = done_cnt;
    pulse_start();
    wait_done("re_done", d0, 200);
    chk("re_count", wr_count, 10);
    chk("re_sb_empty", sb.size(), 0);

`ifdef PUL_PROFILE_CONST_EN
    set_params(1000, 100, 200, 5, 3);
    push_profile(1000, 100, 200, 5, 3);
    saw_const = 1'b0;
    d0 = done_cnt;
    pulse_start();
    wait_done("const_done", d0, 200);
    chk("const_count", wr_count, 13);
    chk("const_sb_empty", sb.size(), 0);
    chk("const_phase_seen", saw_const, 1);
`else
    chk("no_const_phase", saw_const, 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
